pipelined_control: RTL and testbench

- Parametrised next-generation instruction decode/control unit for the 16-bit myMIPS core, between ROM fetch and the execute/memory/write-back datapath.
- Adds to the current controller:
  - valid/ready handshake with fetch;
  - load-use hazard stall;
  - configurable-depth flush ("silence") after taken control transfers;
  - illegal-opcode detection;
  - parametrised register-address width.
- All control outputs are registered; there is one decode stage.

---
 rtl/pipelined_control_if.sv | 11 +
 rtl/pipelined_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipelined_control.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_if.sv
// Fetch-to-decode instruction handshake for the myMIPS pipelined control unit.
interface pipelined_control_if #(
  parameter int INSTR_W = 16
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic               instr_ready;

  modport master (output instr_valid, output instr_data, input  instr_ready);
  modport slave  (input  instr_valid, input  instr_data, output instr_ready);
endinterface

// File: rtl/pipelined_control.sv
// Single-stage decode/control unit for the 16-bit myMIPS core: valid/ready fetch
// handshake, load-use stall, post-jump/branch squash and illegal-opcode detection.
module pipelined_control #(
  parameter int                INSTR_W     = 16,
  parameter int                REG_AW      = 4,
  parameter int                FLUSH_DEPTH = 3,
  parameter logic [REG_AW-1:0] LINK_REG    = '1
) (
  input  logic               clk,
  input  logic               rst,
  pipelined_control_if.slave fetch,
  input  logic               branch_taken,
  output logic               dec_valid,
  output logic [REG_AW-1:0]  addr_rs,
  output logic [REG_AW-1:0]  addr_rt,
  output logic [REG_AW-1:0]  addr_rd,
  output logic               rd_rs,
  output logic               rd_rt,
  output logic [5:0]         imm,
  output logic [2:0]         shamt,
  output logic [11:0]        jaddr,
  output logic [2:0]         alu_cmd,
  output logic               op2_sel,
  output logic               shamt_imm_sel,
  output logic               res_sel,
  output logic               jump_sel,
  output logic               beq_sel,
  output logic               wb_sel,
  output logic               save_pc_sel,
  output logic               ram_rd,
  output logic               ram_wr,
  output logic               wb_wr,
  output logic [REG_AW-1:0]  wb_waddr,
  output logic               flush_active,
  output logic               illegal_op
);
  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_SLL = 3'b010,
                         ALU_SLT = 3'b011, ALU_SRL = 3'b100, ALU_AND = 3'b101,
                         ALU_OR  = 3'b110, ALU_EQ  = 3'b111;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

  typedef struct packed {
    logic [2:0]        alu_cmd;
    logic              op2_sel;
    logic              shamt_imm_sel;
    logic              res_sel;
    logic              jump_sel;
    logic              beq_sel;
    logic              wb_sel;
    logic              save_pc_sel;
    logic              ram_rd;
    logic              ram_wr;
    logic              wb_wr;
    logic [REG_AW-1:0] wb_waddr;
    logic              illegal;
  } ctrl_t;

  // Control word of a bubble: also the reset value of the registered outputs.
  function automatic ctrl_t idle_ctrl();
    ctrl_t c;
    c         = '0;
    c.res_sel = 1'b1;
    c.beq_sel = 1'b1;
    return c;
  endfunction

  state_t     state;
  logic [3:0] flush_cnt;
  logic       rd_en;
  ctrl_t      ctrl_q;
  ctrl_t      dec;
  logic       dec_flush;
  logic       stall;
  logic       accept;
  logic [3:0] opcode;
  logic [2:0] fcode;

  assign opcode  = fetch.instr_data[15:12];
  assign fcode   = fetch.instr_data[2:0];
  assign addr_rs = REG_AW'(fetch.instr_data[11:9]);
  assign addr_rt = REG_AW'(fetch.instr_data[8:6]);
  assign addr_rd = REG_AW'(fetch.instr_data[5:3]);

  // A live lw in the output register whose non-zero target feeds the incoming word.
  assign stall = (state == RUN) && fetch.instr_valid && dec_valid && ctrl_q.ram_rd &&
                 (ctrl_q.wb_waddr != '0) &&
                 ((ctrl_q.wb_waddr == addr_rs) || (ctrl_q.wb_waddr == addr_rt));

  assign fetch.instr_ready = ((state == RUN) && !stall) || (state == STALL) || (state == FLUSH);
  assign accept            = fetch.instr_valid && fetch.instr_ready;

  always_comb begin
    dec       = idle_ctrl();
    dec_flush = 1'b0;
    case (opcode)
      4'd0: begin
        dec.wb_wr    = 1'b1;
        dec.wb_waddr = addr_rd;
        case (fcode)
          3'd0: dec.alu_cmd = ALU_ADD;
          3'd1: dec.alu_cmd = ALU_SUB;
          3'd2: dec.alu_cmd = ALU_AND;
          3'd3: dec.alu_cmd = ALU_OR;
          3'd4: dec.alu_cmd = ALU_SLT;
          3'd5: begin
            dec.alu_cmd       = ALU_SLL;
            dec.op2_sel       = 1'b1;
            dec.shamt_imm_sel = 1'b1;
          end
          3'd6: begin
            dec.alu_cmd       = ALU_SRL;
            dec.op2_sel       = 1'b1;
            dec.shamt_imm_sel = 1'b1;
          end
          default: begin
            dec.alu_cmd  = ALU_ADD;
            dec.jump_sel = 1'b1;
            dec.wb_wr    = 1'b0;
            dec.wb_waddr = '0;
            dec_flush    = 1'b1;
          end
        endcase
      end
      4'd1: begin
        dec.op2_sel  = 1'b1;
        dec.wb_sel   = 1'b1;
        dec.wb_wr    = 1'b1;
        dec.wb_waddr = addr_rt;
      end
      4'd3: begin
        dec.alu_cmd  = ALU_SLT;
        dec.op2_sel  = 1'b1;
        dec.wb_wr    = 1'b1;
        dec.wb_waddr = addr_rt;
      end
      4'd4: begin
        dec.op2_sel  = 1'b1;
        dec.ram_rd   = 1'b1;
        dec.res_sel  = 1'b0;
        dec.wb_wr    = 1'b1;
        dec.wb_waddr = addr_rt;
      end
      4'd5: begin
        dec.op2_sel = 1'b1;
        dec.ram_wr  = 1'b1;
      end
      4'd6: begin
        dec.alu_cmd = ALU_EQ;
        dec.beq_sel = 1'b0;
      end
      4'd7: begin
        dec.op2_sel  = 1'b1;
        dec.jump_sel = 1'b1;
        dec_flush    = 1'b1;
      end
      4'd8: begin
        dec.op2_sel     = 1'b1;
        dec.jump_sel    = 1'b1;
        dec.wb_sel      = 1'b1;
        dec.save_pc_sel = 1'b1;
        dec.wb_wr       = 1'b1;
        dec.wb_waddr    = LINK_REG;
        dec_flush       = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Outputs default to a bubble each edge; branch_taken outranks every other action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      flush_cnt    <= '0;
      flush_active <= 1'b0;
      rd_en        <= 1'b0;
      ctrl_q       <= idle_ctrl();
      dec_valid    <= 1'b0;
      imm          <= '0;
      shamt        <= '0;
      jaddr        <= '0;
    end else begin
      rd_en     <= 1'b1;
      ctrl_q    <= idle_ctrl();
      dec_valid <= 1'b0;
      imm       <= '0;
      shamt     <= '0;
      jaddr     <= '0;
      if (branch_taken) begin
        state        <= FLUSH;
        flush_cnt    <= FLUSH_LOAD;
        flush_active <= 1'b1;
      end else begin
        case (state)
          BOOT: state <= RUN;
          FLUSH: begin
            flush_cnt <= flush_cnt - 4'd1;
            if (flush_cnt == 4'd1) begin
              state        <= RUN;
              flush_active <= 1'b0;
            end
          end
          default: begin
            if (stall) begin
              state <= STALL;
            end else if (accept) begin
              ctrl_q    <= dec;
              dec_valid <= 1'b1;
              imm       <= fetch.instr_data[5:0];
              shamt     <= fetch.instr_data[5:3];
              jaddr     <= fetch.instr_data[11:0];
              if (dec_flush) begin
                state        <= FLUSH;
                flush_cnt    <= FLUSH_LOAD;
                flush_active <= 1'b1;
              end else begin
                state <= RUN;
              end
            end else begin
              state <= RUN;
            end
          end
        endcase
      end
    end
  end

  assign rd_rs         = rd_en;
  assign rd_rt         = rd_en;
  assign alu_cmd       = ctrl_q.alu_cmd;
  assign op2_sel       = ctrl_q.op2_sel;
  assign shamt_imm_sel = ctrl_q.shamt_imm_sel;
  assign res_sel       = ctrl_q.res_sel;
  assign jump_sel      = ctrl_q.jump_sel;
  assign beq_sel       = ctrl_q.beq_sel;
  assign wb_sel        = ctrl_q.wb_sel;
  assign save_pc_sel   = ctrl_q.save_pc_sel;
  assign ram_rd        = ctrl_q.ram_rd;
  assign ram_wr        = ctrl_q.ram_wr;
  assign wb_wr         = ctrl_q.wb_wr;
  assign wb_waddr      = ctrl_q.wb_waddr;
  assign illegal_op    = ctrl_q.illegal;
endmodule

// File: tb/tb_pipelined_control.sv
// Directed-vector bench for pipelined_control: decode table, stall, flush and reset corners.
module tb_pipelined_control;
  localparam int C_NOP   = 'b0010100000;
  localparam int C_ALU   = 'b0010100001;
  localparam int C_SHIFT = 'b1110100001;
  localparam int C_ADDI  = 'b1010110001;
  localparam int C_SLTI  = 'b1010100001;
  localparam int C_LW    = 'b1000100101;
  localparam int C_SW    = 'b1010100010;
  localparam int C_BEQ   = 'b0010000000;
  localparam int C_J     = 'b1011100000;
  localparam int C_JAL   = 'b1011111001;
  localparam int C_JR    = 'b0011100000;
  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SRL = 4, A_AND = 5, A_OR = 6, A_EQ = 7;

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        branch;
    logic        ready;
    logic        dv;
    logic [2:0]  alu;
    logic [9:0]  ctrl;
    logic [3:0]  wa;
    logic        fa;
    logic        ill;
    logic [11:0] ja;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic        dec_valid, rd_rs, rd_rt;
  logic [3:0]  addr_rs, addr_rt, addr_rd, wb_waddr;
  logic [5:0]  imm;
  logic [2:0]  shamt, alu_cmd;
  logic [11:0] jaddr;
  logic        op2_sel, shamt_imm_sel, res_sel, jump_sel, beq_sel, wb_sel, save_pc_sel;
  logic        ram_rd, ram_wr, wb_wr, flush_active, illegal_op;
  logic [9:0]  ctrl;
  int          checks;
  int          errors;
  vec_t        vecs[$];

  pipelined_control_if #(.INSTR_W(16)) fetch_bus ();

  pipelined_control #(
    .INSTR_W(16), .REG_AW(4), .FLUSH_DEPTH(3), .LINK_REG(4'hF)
  ) dut (
    .clk(clk), .rst(rst), .fetch(fetch_bus), .branch_taken(branch_taken),
    .dec_valid(dec_valid), .addr_rs(addr_rs), .addr_rt(addr_rt), .addr_rd(addr_rd),
    .rd_rs(rd_rs), .rd_rt(rd_rt), .imm(imm), .shamt(shamt), .jaddr(jaddr),
    .alu_cmd(alu_cmd), .op2_sel(op2_sel), .shamt_imm_sel(shamt_imm_sel), .res_sel(res_sel),
    .jump_sel(jump_sel), .beq_sel(beq_sel), .wb_sel(wb_sel), .save_pc_sel(save_pc_sel),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .wb_wr(wb_wr), .wb_waddr(wb_waddr),
    .flush_active(flush_active), .illegal_op(illegal_op)
  );

  assign ctrl = {op2_sel, shamt_imm_sel, res_sel, jump_sel, beq_sel,
                 wb_sel, save_pc_sel, ram_rd, ram_wr, wb_wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare_value(input string name, input int row,
                               input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h required 0x%0h", name, row, actual, expected);
    end
  endtask

  task automatic add_vec(input int v, input int d, input int br, input int rdy, input int dv,
                         input int alu, input int c, input int wa, input int fa,
                         input int ill, input int ja);
    vec_t r;
    r.valid  = v[0];
    r.data   = d[15:0];
    r.branch = br[0];
    r.ready  = rdy[0];
    r.dv     = dv[0];
    r.alu    = alu[2:0];
    r.ctrl   = c[9:0];
    r.wa     = wa[3:0];
    r.fa     = fa[0];
    r.ill    = ill[0];
    r.ja     = ja[11:0];
    vecs.push_back(r);
  endtask

  task automatic add_bub(input int v, input int d, input int br, input int rdy, input int fa);
    add_vec(v, d, br, rdy, 0, A_ADD, C_NOP, 0, fa, 0, 0);
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    compare_value("dec_valid", row, 32'(dec_valid), 32'(v.dv));
    compare_value("alu_cmd", row, 32'(alu_cmd), 32'(v.alu));
    compare_value("ctrl_bits", row, 32'(ctrl), 32'(v.ctrl));
    compare_value("wb_waddr", row, 32'(wb_waddr), 32'(v.wa));
    compare_value("flush_active", row, 32'(flush_active), 32'(v.fa));
    compare_value("illegal_op", row, 32'(illegal_op), 32'(v.ill));
    compare_value("fields", row, 32'({jaddr, imm, shamt}), 32'({v.ja, v.ja[5:0], v.ja[5:3]}));
    compare_value("rd_en", row, 32'({rd_rs, rd_rt}), 32'(2'b11));
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    fetch_bus.instr_valid = v.valid;
    fetch_bus.instr_data  = v.data;
    branch_taken          = v.branch;
    #1;
    compare_value("instr_ready", row, 32'(fetch_bus.instr_ready), 32'(v.ready));
    compare_value("reg_addrs", row, 32'({addr_rs, addr_rt, addr_rd}),
                  32'({1'b0, v.data[11:9], 1'b0, v.data[8:6], 1'b0, v.data[5:3]}));
    @(posedge clk);
    #1;
    checkOutput(v, row);
  endtask

  task automatic check_reset_state(input int row);
    compare_value("rst_dec_valid", row, 32'(dec_valid), 32'(0));
    compare_value("rst_alu_cmd", row, 32'(alu_cmd), 32'(0));
    compare_value("rst_ctrl_bits", row, 32'(ctrl), 32'(C_NOP));
    compare_value("rst_wb_waddr", row, 32'(wb_waddr), 32'(0));
    compare_value("rst_flush_active", row, 32'(flush_active), 32'(0));
    compare_value("rst_illegal_op", row, 32'(illegal_op), 32'(0));
    compare_value("rst_fields", row, 32'({jaddr, imm, shamt}), 32'(0));
    compare_value("rst_instr_ready", row, 32'(fetch_bus.instr_ready), 32'(0));
    compare_value("rst_rd_en", row, 32'({rd_rs, rd_rt}), 32'(0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    branch_taken = 1'b0;
    fetch_bus.instr_valid = 1'b0;
    fetch_bus.instr_data  = 16'h0000;

    //      v  data    br rdy dv alu    ctrl     wa  fa ill jaddr
    add_bub(1, 'h0008, 0, 0, 0);
    add_vec(1, 'h0008, 0, 1, 1, A_ADD, C_ALU,   1,  0, 0, 'h008);
    add_vec(1, 'h0729, 0, 1, 1, A_SUB, C_ALU,   5,  0, 0, 'h729);
    add_vec(1, 'h02B2, 0, 1, 1, A_AND, C_ALU,   6,  0, 0, 'h2B2);
    add_vec(1, 'h003B, 0, 1, 1, A_OR,  C_ALU,   7,  0, 0, 'h03B);
    add_vec(1, 'h000C, 0, 1, 1, A_SLT, C_ALU,   1,  0, 0, 'h00C);
    add_vec(1, 'h0015, 0, 1, 1, A_SLL, C_SHIFT, 2,  0, 0, 'h015);
    add_vec(1, 'h001E, 0, 1, 1, A_SRL, C_SHIFT, 3,  0, 0, 'h01E);
    add_vec(1, 'h12AA, 0, 1, 1, A_ADD, C_ADDI,  2,  0, 0, 'h2AA);
    add_vec(1, 'h34C5, 0, 1, 1, A_SLT, C_SLTI,  3,  0, 0, 'h4C5);
    add_vec(1, 'h5283, 0, 1, 1, A_ADD, C_SW,    0,  0, 0, 'h283);
    add_vec(1, 'h6284, 0, 1, 1, A_EQ,  C_BEQ,   0,  0, 0, 'h284);
    add_vec(1, 'hF123, 0, 1, 1, A_ADD, C_NOP,   0,  0, 1, 'h123);
    add_vec(1, 'h2000, 0, 1, 1, A_ADD, C_NOP,   0,  0, 1, 'h000);
    add_bub(0, 'h0000, 0, 1, 0);
    // load-use on rs, zero target, no-valid, load-use on rt
    add_vec(1, 'h4280, 0, 1, 1, A_ADD, C_LW,    2,  0, 0, 'h280);
    add_bub(1, 'h0450, 0, 0, 0);
    add_vec(1, 'h0450, 0, 1, 1, A_ADD, C_ALU,   2,  0, 0, 'h450);
    add_vec(1, 'h4200, 0, 1, 1, A_ADD, C_LW,    0,  0, 0, 'h200);
    add_vec(1, 'h0000, 0, 1, 1, A_ADD, C_ALU,   0,  0, 0, 'h000);
    add_vec(1, 'h4280, 0, 1, 1, A_ADD, C_LW,    2,  0, 0, 'h280);
    add_bub(0, 'h0450, 0, 1, 0);
    add_vec(1, 'h4280, 0, 1, 1, A_ADD, C_LW,    2,  0, 0, 'h280);
    add_bub(1, 'h0098, 0, 0, 0);
    add_vec(1, 'h0098, 0, 1, 1, A_ADD, C_ALU,   3,  0, 0, 'h098);
    // j then four adds
    add_vec(1, 'h7005, 0, 1, 1, A_ADD, C_J,     0,  1, 0, 'h005);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 0);
    add_vec(1, 'h0008, 0, 1, 1, A_ADD, C_ALU,   1,  0, 0, 'h008);
    // branch_taken in the second flush cycle reloads the counter
    add_vec(1, 'h7005, 0, 1, 1, A_ADD, C_J,     0,  1, 0, 'h005);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 1, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 0);
    add_vec(1, 'h0008, 0, 1, 1, A_ADD, C_ALU,   1,  0, 0, 'h008);
    // branch_taken in RUN discards the word on that edge
    add_bub(1, 'h0008, 1, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 0);
    add_vec(1, 'h0008, 0, 1, 1, A_ADD, C_ALU,   1,  0, 0, 'h008);
    // jal, illegal word squashed, then jr with idle fetch
    add_vec(1, 'h8010, 0, 1, 1, A_ADD, C_JAL,  15,  1, 0, 'h010);
    add_bub(1, 'hF000, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 1);
    add_bub(1, 'h0008, 0, 1, 0);
    add_vec(1, 'h0207, 0, 1, 1, A_ADD, C_JR,    0,  1, 0, 'h207);
    add_bub(0, 'h0000, 0, 1, 1);
    add_bub(0, 'h0000, 0, 1, 1);
    add_bub(0, 'h0000, 0, 1, 0);
    add_vec(1, 'h0008, 0, 1, 1, A_ADD, C_ALU,   1,  0, 0, 'h008);
    // stall pending at branch_taken is dropped
    add_vec(1, 'h4280, 0, 1, 1, A_ADD, C_LW,    2,  0, 0, 'h280);
    add_bub(1, 'h0450, 1, 0, 1);
    add_bub(0, 'h0000, 0, 1, 1);
    add_bub(0, 'h0000, 0, 1, 1);
    add_bub(0, 'h0000, 0, 1, 0);
    add_vec(1, 'h0450, 0, 1, 1, A_ADD, C_ALU,   2,  0, 0, 'h450);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state(-1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // async reset between edges while squashing after a jump
    fetch_bus.instr_valid = 1'b1;
    fetch_bus.instr_data  = 16'h7005;
    branch_taken          = 1'b0;
    @(posedge clk);
    #1;
    compare_value("pre_rst_flush", 100, 32'(flush_active), 32'(1));
    fetch_bus.instr_data = 16'h0008;
    @(posedge clk);
    #1;
    compare_value("pre_rst_flush", 101, 32'(flush_active), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(102);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(vecs[0], 103);
    applyStimulus(vecs[1], 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
